// File: rtl/piso4_tx_if.sv
// Load channel of the serializer: parallel word plus valid/ready handshake.
// A word is taken on any rising edge where LD_VALID and LD_READY are both high.
interface piso4_tx_if #(
    parameter int W = 4
);
    logic [W-1:0] D;
    logic         LD_VALID;
    logic         LD_READY;

    modport master (
        output D,
        output LD_VALID,
        input  LD_READY
    );

    modport slave (
        input  D,
        input  LD_VALID,
        output LD_READY
    );
endinterface

// File: rtl/piso4_tx.sv
// Parallel-in serial-out transmitter, MSB first, advancing one bit per (TICK & CE).
// TICK comes from a free-running divider and is exported for a paired receiver.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | ready for a load, SLO held low
//   S_SHIFT | frame in progress, SLO = sreg MSB, advances on TICK & CE
//   S_DONE  | one-cycle completion pulse, always returns to S_IDLE
module piso4_tx #(
    parameter int W        = 4,
    parameter int TICK_DIV = 33554432
) (
    input  logic          CLK,
    input  logic          R_N,
    input  logic          CE,
    piso4_tx_if.slave     ld,
    output logic          SLO,
    output logic          TICK,
    output logic          BUSY,
    output logic          DONE
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(W + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(W);
    localparam logic [BW-1:0] BIT_LAST = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic          tick_q;
    logic [W-1:0]  sreg;
    logic [BW-1:0] bitcnt;
    logic          slo_q;
    logic          busy_q;
    logic          done_q;
    logic          ld_ready_q;
    logic          advance;

    // Divider free-runs: never gated by CE, state or loads.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign advance = tick_q & CE;

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state      <= S_IDLE;
            sreg       <= '0;
            bitcnt     <= '0;
            slo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    busy_q     <= 1'b0;
                    slo_q      <= 1'b0;
                    ld_ready_q <= 1'b1;
                    // A tick coinciding with the load is deliberately not applied to the new frame.
                    if (ld.LD_VALID && ld_ready_q) begin
                        sreg       <= ld.D;
                        bitcnt     <= BIT_FULL;
                        state      <= S_SHIFT;
                        slo_q      <= ld.D[W-1];
                        busy_q     <= 1'b1;
                        ld_ready_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (advance) begin
                        sreg   <= {sreg[W-2:0], 1'b0};
                        bitcnt <= bitcnt - 1'b1;
                        if (bitcnt == BIT_LAST) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            slo_q  <= 1'b0;
                        end else begin
                            slo_q <= sreg[W-2];
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                    slo_q      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign SLO         = slo_q;
    assign TICK        = tick_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ld.LD_READY = ld_ready_q;
endmodule

// File: tb/tb_piso4_tx.sv
// Scoreboard bench for piso4_tx: loads push expected bits/words, a negedge monitor
// pops them on every advance and on DONE, acting as a loopback serial-in receiver.
module tb_piso4_tx;
    localparam int W  = 4;
    localparam int TD = 4;

    logic CLK = 1'b0;
    logic R_N;
    logic CE;
    logic ce0;
    logic SLO, TICK, BUSY, DONE;
    logic SLO1, TICK1, BUSY1, DONE1;

    piso4_tx_if #(.W(W)) ld_if ();
    piso4_tx_if #(.W(W)) ld_if1 ();

    always #5 CLK = ~CLK;

    piso4_tx #(.W(W), .TICK_DIV(TD)) u_dut (
        .CLK (CLK),
        .R_N (R_N),
        .CE  (CE),
        .ld  (ld_if.slave),
        .SLO (SLO),
        .TICK(TICK),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    piso4_tx #(.W(W), .TICK_DIV(1)) u_dut1 (
        .CLK (CLK),
        .R_N (R_N),
        .CE  (ce0),
        .ld  (ld_if1.slave),
        .SLO (SLO1),
        .TICK(TICK1),
        .BUSY(BUSY1),
        .DONE(DONE1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int adv = 0;
    int hs_gap = 0;
    int done_cyc = -100;
    int last_tick = -1;
    int hi_cnt = 0;
    bit ce_rand = 0;
    bit prev_done = 0;
    logic [W-1:0] rx = '0;
    logic exp_bits[$];
    logic [W-1:0] exp_words[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic monitor();
        logic [W-1:0] w;
        logic b;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!R_N) begin
                exp_bits.delete();
                exp_words.delete();
                last_tick = -1;
                hi_cnt = 0;
                prev_done = 0;
                adv = 0;
                rx = '0;
            end else begin
                hi_cnt++;
                if (hi_cnt >= 2) check("tick_div1_high", 32'(TICK1), 32'd1);
                if (TICK) begin
                    if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(TD));
                    last_tick = cyc;
                end
                if (prev_done) check("after_done_rdy_busy_done", 32'({LD_READY_w(), BUSY, DONE}), 32'b100);
                if (hi_cnt >= 2 && !BUSY && !DONE) check("idle_slo_rdy", 32'({SLO, ld_if.LD_READY}), 32'b01);
                if (DONE) begin
                    check("done_busy_rdy_slo", 32'({BUSY, ld_if.LD_READY, SLO}), 32'b100);
                    if (exp_words.size() == 0) begin
                        timeout("unexpected_done");
                    end else begin
                        w = exp_words.pop_front();
                        check("rx_word", 32'(rx), 32'(w));
                        check("advances_per_frame", 32'(adv), 32'(W));
                        check("bits_left", 32'(exp_bits.size()), 32'd0);
                    end
                    done_cyc = cyc;
                end else if (BUSY && TICK && CE) begin
                    if (exp_bits.size() == 0) begin
                        timeout("unexpected_advance");
                    end else begin
                        b = exp_bits.pop_front();
                        check("slo_bit", 32'(SLO), 32'(b));
                    end
                    rx = {rx[W-2:0], SLO};
                    adv++;
                end
                prev_done = DONE;
                if (ld_if.LD_VALID && ld_if.LD_READY) begin
                    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(((ld_if.D >> i) & 1) != 0);
                    exp_words.push_back(ld_if.D);
                    hs_gap = cyc - done_cyc;
                    adv = 0;
                    rx = '0;
                end
            end
        end
    endtask

    function automatic logic LD_READY_w();
        return ld_if.LD_READY;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        if (ce_rand) CE = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load_word(input logic [W-1:0] d);
        bit acc = 0;
        bit rdy;
        int i = 0;
        ld_if.D = d;
        ld_if.LD_VALID = 1'b1;
        while (!acc && i < 200) begin
            rdy = ld_if.LD_READY;
            step();
            acc = rdy;
            i++;
        end
        if (!acc) timeout("load_accept");
        ld_if.LD_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (DONE !== 1'b1 && i < 500) begin
            step();
            i++;
        end
        if (DONE !== 1'b1) timeout("wait_done");
    endtask

    task automatic wait_adv(input int n);
        int i = 0;
        while (adv < n && i < 200) begin
            step();
            i++;
        end
        if (adv < n) timeout("wait_advance");
    endtask

    initial begin
        int vals[16];
        int j, t;
        R_N = 1'b0;
        CE = 1'b0;
        ce0 = 1'b0;
        ld_if.D = '0;
        ld_if.LD_VALID = 1'b0;
        ld_if1.D = '0;
        ld_if1.LD_VALID = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) step();
        check("reset_outputs", 32'({SLO, TICK, BUSY, DONE, ld_if.LD_READY}), 32'd0);
        check("reset_tick_div1", 32'(TICK1), 32'd0);
        R_N = 1'b1;
        check("ready_before_first_edge", 32'(ld_if.LD_READY), 32'd0);
        step();
        check("ready_after_first_edge", 32'({ld_if.LD_READY, BUSY}), 32'b10);

        // basic frame 1011
        CE = 1'b1;
        load_word(4'b1011);
        check("load_busy_rdy_slo", 32'({BUSY, ld_if.LD_READY, SLO}), 32'b101);
        wait_done();
        step();
        check("ready_after_frame", 32'(ld_if.LD_READY), 32'd1);

        // load coinciding with a tick
        t = 0;
        while (!(TICK === 1'b1 && ld_if.LD_READY === 1'b1) && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) timeout("find_tick");
        load_word(4'b0101);
        wait_done();

        // CE freeze mid-frame
        step();
        load_word(4'b1100);
        wait_adv(1);
        CE = 1'b0;
        repeat (10) begin
            step();
            check("freeze_slo", 32'(SLO), 32'd1);
            check("freeze_busy", 32'(BUSY), 32'd1);
        end
        CE = 1'b1;
        wait_done();

        // load attempt during SHIFT ignored, held through DONE -> back-to-back
        step();
        load_word(4'b1011);
        step();
        step();
        ld_if.D = 4'b0110;
        ld_if.LD_VALID = 1'b1;
        check("ready_low_in_shift", 32'(ld_if.LD_READY), 32'd0);
        wait_done();
        load_word(4'b0110);
        check("b2b_gap", 32'(hs_gap), 32'd1);
        wait_done();

        // reset mid-frame
        step();
        load_word(4'b0111);
        wait_adv(2);
        #2;
        R_N = 1'b0;
        #1;
        check("async_reset_outputs", 32'({SLO, TICK, BUSY, DONE, ld_if.LD_READY}), 32'd0);
        step();
        step();
        check("held_reset_no_done", 32'({BUSY, DONE}), 32'd0);
        R_N = 1'b1;
        step();
        load_word(4'b1001);
        wait_done();

        // loopback of all 16 words, shuffled, with random CE, then random words
        for (int i = 0; i < 16; i++) vals[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        ce_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 4)) step();
            load_word(4'(vals[i]));
            wait_done();
        end
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) step();
            load_word(4'($urandom_range(0, 15)));
            wait_done();
        end
        ce_rand = 1'b0;
        CE = 1'b1;
        repeat (6) step();
        check("scoreboard_drained", 32'(exp_words.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
